operand_fetch: RTL



---
 rtl/rf_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 42 ++++
 rtl/operand_fetch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, the hard-wired zero register and
// the decoded-instruction payload seen by operand fetch.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              rd_we;
    } instr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue, cleared by
// write-back (set wins on the same register), with three combinational lookups.
module reg_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] q_a,
    input  logic [ADDR_W-1:0] q_b,
    input  logic [ADDR_W-1:0] q_c,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_c
);

    logic [NUM_REGS-1:0] busy;

    // Entry 0 is skipped so the zero register can never look pending.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (set_en && set_addr == ADDR_W'(i)) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && clr_addr == ADDR_W'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_a = busy[q_a];
    assign busy_b = busy[q_b];
    assign busy_c = busy[q_c];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads the register file, bypasses write-back, stalls on
// pending writes and hands operands to execute through a one-entry register.
module operand_fetch #(
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int ADDR_W   = rf_pkg::ADDR_W,
    parameter int NUM_REGS = rf_pkg::NUM_REGS,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [ADDR_W-1:0] rf_rd_addrA,
    output logic [ADDR_W-1:0] rf_rd_addrB,
    input  logic [DATA_W-1:0] rf_rd_dataA,
    input  logic [DATA_W-1:0] rf_rd_dataB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_opA,
    output logic [DATA_W-1:0] out_opB,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_we,
    output logic [CNT_W-1:0]  stall_cnt
);

    import rf_pkg::*;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] sel_operand(input logic [ADDR_W-1:0] rs,
                                                      input logic              fwd,
                                                      input logic [DATA_W-1:0] byp,
                                                      input logic [DATA_W-1:0] rf_data);
        if (rs == ZERO_REG) return '0;
        if (fwd)            return byp;
        return rf_data;
    endfunction

    instr_t            instr_p0;
    logic              fwd_rs1, fwd_rs2, fwd_rd;
    logic              busy_rs1, busy_rs2, busy_rd;
    logic              raw, waw, hazard, slot_free;
    logic              fire_in, fire_out, sb_set;
    logic [DATA_W-1:0] opa_p0, opb_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] opa_p1, opb_p1;
    logic [ADDR_W-1:0] rd_p1;
    logic              rd_we_p1;
    logic [CNT_W-1:0]  stall_q;

    // Stage p0: register-file read, bypass and hazard detection
    assign instr_p0 = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, rd_we: in_rd_we};

    assign rf_rd_addrA = instr_p0.rs1;
    assign rf_rd_addrB = instr_p0.rs2;
    assign rf_wr_en    = nrst & wb_valid & (wb_addr != ZERO_REG);
    assign rf_wr_addr  = wb_addr;
    assign rf_wr_data  = wb_data;

    assign fwd_rs1 = wb_valid && (wb_addr == instr_p0.rs1);
    assign fwd_rs2 = wb_valid && (wb_addr == instr_p0.rs2);
    assign fwd_rd  = wb_valid && (wb_addr == instr_p0.rd);

    assign opa_p0 = sel_operand(instr_p0.rs1, fwd_rs1, wb_data, rf_rd_dataA);
    assign opb_p0 = sel_operand(instr_p0.rs2, fwd_rs2, wb_data, rf_rd_dataB);

    // A write-back landing this cycle resolves the hazard it would otherwise cause.
    assign raw = ((instr_p0.rs1 != ZERO_REG) && busy_rs1 && !fwd_rs1) ||
                 ((instr_p0.rs2 != ZERO_REG) && busy_rs2 && !fwd_rs2);
    assign waw = instr_p0.rd_we && (instr_p0.rd != ZERO_REG) && busy_rd && !fwd_rd;
    assign hazard = in_valid && (raw || waw);

    assign slot_free = !vld_p1 || out_ready;
    assign in_ready  = nrst && slot_free && !hazard;
    assign fire_in   = in_valid && in_ready;
    assign fire_out  = vld_p1 && out_ready;
    assign sb_set    = fire_in && instr_p0.rd_we && (instr_p0.rd != ZERO_REG);

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .nrst     (nrst),
        .set_en   (sb_set),
        .set_addr (instr_p0.rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .q_a      (instr_p0.rs1),
        .q_b      (instr_p0.rs2),
        .q_c      (instr_p0.rd),
        .busy_a   (busy_rs1),
        .busy_b   (busy_rs2),
        .busy_c   (busy_rd)
    );

    // Stage p1: output register towards execute
    always_ff @(posedge clk) begin
        if (!nrst) begin
            vld_p1   <= 1'b0;
            opa_p1   <= '0;
            opb_p1   <= '0;
            rd_p1    <= '0;
            rd_we_p1 <= 1'b0;
        end else if (fire_in) begin
            vld_p1   <= 1'b1;
            opa_p1   <= opa_p0;
            opb_p1   <= opb_p0;
            rd_p1    <= instr_p0.rd;
            rd_we_p1 <= instr_p0.rd_we;
        end else if (fire_out) begin
            vld_p1   <= 1'b0;
        end
    end

    // Only cycles where the output slot could have taken the instruction count as stalls.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_q <= '0;
        end else if (hazard && slot_free) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign out_valid = vld_p1;
    assign out_opA   = opa_p1;
    assign out_opB   = opb_p1;
    assign out_rd    = rd_p1;
    assign out_rd_we = rd_we_p1;
    assign stall_cnt = stall_q;

endmodule
